spi_slave_fifo: RTL

Parametrised SPI slave that generalises the fixed 8-bit, compile-time-phase slave: configurable word width and bit order, runtime-selectable SPI mode (CPOL/CPHA), and built-in TX/RX FIFOs with valid/ready handshakes and underrun/overrun reporting. It sits between an external SPI master pin interface and the system-clock fabric. Multi-word bursts under one `ss_n` assertion run without per-word software service.

---
 rtl/spi_slave_fifo.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_fifo.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_fifo (with helper spi_slave_fifo_buf)
// Purpose  : SPI slave with configurable word width and bit order, a
//            runtime-selectable SPI mode, and TX/RX FIFOs with handshakes.
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Show-ahead synchronous FIFO. PUSH_ON_FULL_POP lets a push into a full FIFO
// succeed when a pop happens in the same cycle.
// ----------------------------------------------------------------------------
module spi_slave_fifo_buf #(
  parameter int unsigned WIDTH            = 8,
  parameter int unsigned DEPTH            = 4,
  parameter bit          PUSH_ON_FULL_POP = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             w_push_ok, w_pop_ok;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (PTR_W+1)'(DEPTH));
  assign w_pop_ok  = pop_i & ~empty_o;
  assign w_push_ok = push_i & (~full_o | (PUSH_ON_FULL_POP & w_pop_ok));
  // Read data is forced to zero while empty so the output is defined
  assign rdata_o   = empty_o ? '0 : mem_q[rptr_q];
  assign count_o   = count_q;

  // Occupancy follows the accepted push/pop pair of this cycle
  always_comb begin
    count_d = count_q;
    if (w_push_ok && !w_pop_ok) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (w_pop_ok && !w_push_ok) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push_ok) wptr_q <= wptr_q + PTR_W'(1);
      if (w_pop_ok)  rptr_q <= rptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage array, written without reset (contents are masked while empty)
  always_ff @(posedge clk) begin
    if (w_push_ok) mem_q[wptr_q] <= wdata_i;
  end
endmodule

// ----------------------------------------------------------------------------
// Top level SPI slave
// ----------------------------------------------------------------------------
module spi_slave_fifo #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       TX_DEPTH  = 4,
  parameter int unsigned       RX_DEPTH  = 4,
  parameter bit                LSB_FIRST = 1'b1,
  parameter logic [DATA_W-1:0] TX_IDLE   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ss_n,
  input  logic                      sclk,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      miso_oe,
  input  logic                      cfg_cpol,
  input  logic                      cfg_cpha,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      tx_underrun,
  output logic                      rx_overrun,
  output logic                      busy
);
  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  // [1] is the synchronised pin, [2] its previous value for edge detection
  logic [2:0]        ss_sync_q, sclk_sync_q;
  logic [1:0]        mosi_sync_q;
  logic              busy_q, cpol_q, cpha_q, first_trail_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] tx_shreg_q;
  logic [DATA_W-2:0] rx_shreg_q;
  logic              tx_underrun_q, rx_overrun_q;

  logic              w_ss_fall, w_ss_rise, w_active;
  logic              w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic              w_sample, w_shift, w_last_bit, w_load;
  logic              w_rx_push, w_rx_pop;
  logic              w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic [DATA_W-1:0] w_tx_shifted, w_rx_next, w_tx_fifo_data;
  logic [DATA_W-2:0] w_rx_keep;

  // Bit-order specific datapath: output end of TX, fill end of RX
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_tx_shifted = {1'b0, tx_shreg_q[DATA_W-1:1]};
      assign w_rx_next    = {mosi_sync_q[1], rx_shreg_q};
      assign w_rx_keep    = w_rx_next[DATA_W-1:1];
      assign miso         = tx_shreg_q[0];
    end else begin : g_msb_first
      assign w_tx_shifted = {tx_shreg_q[DATA_W-2:0], 1'b0};
      assign w_rx_next    = {rx_shreg_q, mosi_sync_q[1]};
      assign w_rx_keep    = w_rx_next[DATA_W-2:0];
      assign miso         = tx_shreg_q[DATA_W-1];
    end
  endgenerate

  assign w_ss_fall   = ss_sync_q[2] & ~ss_sync_q[1];
  assign w_ss_rise   = ~ss_sync_q[2] & ss_sync_q[1];
  assign w_active    = busy_q & ~ss_sync_q[1];
  assign w_sclk_rise = ~sclk_sync_q[2] & sclk_sync_q[1];
  assign w_sclk_fall = sclk_sync_q[2] & ~sclk_sync_q[1];
  assign w_lead      = cpol_q ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = cpol_q ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = w_active & (cpha_q ? w_trail : w_lead);
  assign w_shift     = w_active & (cpha_q ? w_lead : w_trail);
  assign w_last_bit  = (bit_cnt_q == LAST_BIT);
  // CPHA=0 preloads at frame start; the first trailing edge never reloads so
  // a master that starts from the wrong idle level cannot skip that word
  assign w_load      = (w_ss_fall & ~cfg_cpha)
                     | (w_shift & (bit_cnt_q == '0) & (cpha_q | ~first_trail_q));
  assign w_rx_push   = w_sample & w_last_bit;
  assign w_rx_pop    = rx_ready & ~w_rx_empty;

  assign miso_oe     = busy_q;
  assign busy        = busy_q;
  assign tx_ready    = ~w_tx_full;
  assign rx_valid    = ~w_rx_empty;
  assign tx_underrun = tx_underrun_q;
  assign rx_overrun  = rx_overrun_q;

  // Two-flop synchronisers plus one history flop for edge detection;
  // ss_n resets low so only a genuine high-to-low after reset opens a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], ss_n};
      sclk_sync_q <= {sclk_sync_q[1:0], sclk};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
    end
  end

  // Frame tracking: mode latched at ss_n fall, busy until ss_n rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= 1'b0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      first_trail_q <= 1'b0;
    end else if (w_ss_fall) begin
      busy_q        <= 1'b1;
      cpol_q        <= cfg_cpol;
      cpha_q        <= cfg_cpha;
      first_trail_q <= 1'b1;
    end else begin
      if (w_ss_rise)          busy_q        <= 1'b0;
      if (w_active & w_trail) first_trail_q <= 1'b0;
    end
  end

  // Bit counter advanced by sample edges, restarted at every frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
    end else if (w_ss_fall) begin
      bit_cnt_q <= '0;
    end else if (w_sample) begin
      bit_cnt_q <= w_last_bit ? '0 : bit_cnt_q + CNT_W'(1);
    end
  end

  // Shift registers: TX load takes priority over shift, RX collects samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shreg_q <= '0;
      rx_shreg_q <= '0;
    end else begin
      if (w_load) begin
        tx_shreg_q <= w_tx_empty ? TX_IDLE : w_tx_fifo_data;
      end else if (w_shift) begin
        tx_shreg_q <= w_tx_shifted;
      end
      if (w_sample) rx_shreg_q <= w_rx_keep;
    end
  end

  // Single-cycle event flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_underrun_q <= 1'b0;
      rx_overrun_q  <= 1'b0;
    end else begin
      tx_underrun_q <= w_load & w_tx_empty;
      rx_overrun_q  <= w_rx_push & w_rx_full & ~w_rx_pop;
    end
  end

  spi_slave_fifo_buf #(
    .WIDTH            (DATA_W),
    .DEPTH            (TX_DEPTH),
    .PUSH_ON_FULL_POP (1'b0)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (w_load),
    .rdata_o (w_tx_fifo_data),
    .empty_o (w_tx_empty),
    .full_o  (w_tx_full),
    .count_o (tx_level)
  );

  spi_slave_fifo_buf #(
    .WIDTH            (DATA_W),
    .DEPTH            (RX_DEPTH),
    .PUSH_ON_FULL_POP (1'b1)
  ) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_rx_push),
    .wdata_i (w_rx_next),
    .pop_i   (rx_ready),
    .rdata_o (rx_data),
    .empty_o (w_rx_empty),
    .full_o  (w_rx_full),
    .count_o (rx_level)
  );
endmodule
`default_nettype wire
